// File: rtl/fsm_stream_arbiter.sv
// Round-robin scheduler sharing one serial sequence detector among N_REQ requesters.
// Grants a requester, clears the detector, shifts its word MSB-first and returns the hit count.
module fsm_stream_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*WORD_W-1:0]       data,
  output logic [N_REQ-1:0]              gnt,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_REQ)-1:0]      done_id,
  output logic [$clog2(WORD_W+1)-1:0]   hits,
  output logic                          det_rst_n,
  output logic                          det_x,
  input  logic                          det_y
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned HIT_W = $clog2(WORD_W + 1);
  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               busy_q;
  logic               done_q;
  logic [ID_W-1:0]    done_id_q;
  logic [HIT_W-1:0]   hits_q;
  logic               det_rst_n_q;
  logic               det_x_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    gid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  sr_q;
  logic [HIT_W-1:0]   acc_q;

  logic               sel_vld;
  logic [ID_W-1:0]    sel_id;
  logic [WORD_W-1:0]  sel_word;
  int unsigned        scan_idx;
  logic [ID_W-1:0]    ptr_next;

  // First requesting index at or after ptr_q, wrapping modulo N_REQ.
  always_comb begin
    sel_vld  = 1'b0;
    sel_id   = '0;
    sel_word = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % N_REQ;
      if (!sel_vld && req[ID_W'(scan_idx)]) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'(scan_idx);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel_id) begin
        sel_word = data[i*WORD_W +: WORD_W];
      end
    end
  end

  assign ptr_next = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);

  // Transfer sequencer; every output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hits_q      <= '0;
      det_rst_n_q <= 1'b0;
      det_x_q     <= 1'b0;
      ptr_q       <= '0;
      gid_q       <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          det_x_q     <= 1'b0;
          det_rst_n_q <= 1'b1;
          if (sel_vld) begin
            state_q     <= ST_CLEAR;
            gid_q       <= sel_id;
            sr_q        <= sel_word;
            gnt_q       <= N_REQ'(1) << sel_id;
            busy_q      <= 1'b1;
            det_rst_n_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_SHIFT;
          acc_q       <= '0;
          cnt_q       <= '0;
          det_rst_n_q <= 1'b1;
          det_x_q     <= sr_q[WORD_W-1];
          sr_q        <= sr_q << 1;
        end
        ST_SHIFT: begin
          // The first SHIFT cycle still shows the response to the cleared detector.
          if (det_y && (cnt_q != '0)) begin
            acc_q <= acc_q + HIT_W'(1);
          end
          if (cnt_q == CNT_W'(WORD_W - 1)) begin
            state_q <= ST_DRAIN;
            det_x_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            det_x_q <= sr_q[WORD_W-1];
            sr_q    <= sr_q << 1;
          end
        end
        ST_DRAIN: begin
          state_q   <= ST_DONE;
          gnt_q     <= '0;
          done_q    <= 1'b1;
          done_id_q <= gid_q;
          hits_q    <= acc_q + HIT_W'(det_y);
          ptr_q     <= ptr_next;
          det_x_q   <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign hits      = hits_q;
  assign det_rst_n = det_rst_n_q;
  assign det_x     = det_x_q;

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Self-checking bench for fsm_stream_arbiter: a transfer-phase reference model predicts every output each cycle.
module tb_fsm_stream_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(W + 1);
  localparam int VW  = N + 4 + IDW + HW;
  localparam int TL  = W + 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy, done;
  logic [IDW-1:0] done_id;
  logic [HW-1:0]  hits;
  logic           det_rst_n, det_x, det_y;

  always #5 clk = ~clk;

  fsm_stream_arbiter #(.N_REQ(N), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .hits(hits), .det_rst_n(det_rst_n),
    .det_x(det_x), .det_y(det_y)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int det_mode = 0;
  logic last_x = 1'b0;

  // Reference state: position within a transfer (0 idle, 1 clear, 2..W+1 shift, W+2 drain, W+3 done).
  int m_phase = 0, m_gid = 0, m_acc = 0, m_ptr = 0, m_hits = 0, m_done_id = 0;
  bit m_after_rst = 1'b1;
  logic [W-1:0] m_word = '0;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] obs_vec();
    return {gnt, busy, done, det_rst_n, det_x, done_id, hits};
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int k;
    k = -1;
    for (int i = 0; i < N; i++) if (v[i]) k = i;
    return k;
  endfunction

  task automatic model_update();
    bit found;
    int id;
    logic [N-1:0] eg;
    logic ex;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_hits = 0; m_done_id = 0; m_acc = 0; m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      if (m_phase == 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          id = (m_ptr + k) % N;
          if (!found && req[id]) begin
            found = 1'b1; m_gid = id; m_word = data[id*W +: W];
          end
        end
        if (found) begin m_phase = 1; m_acc = 0; end
      end else begin
        if (m_phase >= 3 && m_phase <= W + 2 && det_y) m_acc++;
        if (m_phase == W + 2) begin
          m_hits = m_acc; m_done_id = m_gid; m_ptr = (m_gid + 1) % N;
        end
        m_phase = (m_phase == W + 3) ? 0 : m_phase + 1;
      end
    end
    eg = (m_phase >= 1 && m_phase <= W + 2) ? (N'(1) << m_gid) : '0;
    ex = 1'b0;
    if (m_phase >= 2 && m_phase <= W + 1) ex = m_word[W + 1 - m_phase];
    exp_vec = {eg, 1'(m_phase != 0), 1'(m_phase == W + 3),
               1'(!m_after_rst && m_phase != 1), ex, IDW'(m_done_id), HW'(m_hits)};
  endtask

  // Advance one clock; the detector stand-in drives det_y for the new cycle.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    case (det_mode)
      1:       det_y = 1'($urandom);
      2:       det_y = (m_phase <= 1) ? 1'b1 : last_x;
      default: det_y = last_x;
    endcase
    last_x = det_x;
  endtask

  int t0;

  task automatic test_reset();
    rst = 1'b1; req = '1; data = rand_data(); det_y = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL reset_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      n_checks++;
      if ({gnt, busy, done, hits, det_rst_n, det_x} !== '0) begin
        n_fail++; $display("FAIL reset_values gnt=%b busy=%b done=%b hits=%0d det_rst_n=%b det_x=%b required all zero",
                           gnt, busy, done, hits, det_rst_n, det_x);
      end
    end
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_round_robin();
    int ids[5];
    int starts[5];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int ns = 0, nd = 0;
    logic [N-1:0] pg;
    pg = gnt;
    for (int r = 1; r <= 5 * TL; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL rr_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      if (gnt !== '0 && pg === '0) begin
        if (ns < 5) begin ids[ns] = oh_idx(gnt); starts[ns] = cyc; end
        ns++;
      end
      if (done === 1'b1) nd++;
      pg = gnt;
    end
    req = '0;
    n_checks++;
    if (ns != 5 || nd != 5) begin
      n_fail++; $display("FAIL rr_counts grants=%0d dones=%0d required 5 and 5", ns, nd);
    end
    for (int k = 0; k < 5 && k < ns; k++) begin
      n_checks++;
      if (ids[k] != exp_ids[k] || starts[k] != t0 + 1 + k * TL) begin
        n_fail++; $display("FAIL rr_grant%0d id=%0d at=%0d required id=%0d at=%0d",
                           k, ids[k], starts[k], exp_ids[k], t0 + 1 + k * TL);
      end
    end
  endtask

  task automatic drain_idle();
    req = '0;
    for (int r = 0; r < TL + 2; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL idle_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_single();
    int gc = 0;
    logic [W-1:0] xs = '0;
    drain_idle();
    data = rand_data(); data[W +: W] = 8'hB6; req = 4'b0010;
    for (int r = 1; r <= TL; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL single_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      if (r == 1) begin req = '0; data = rand_data(); end
      if (gnt === 4'b0010) gc++;
      if (r >= 2 && r <= W + 1) xs = {xs[W-2:0], det_x};
      if (r == W + 3) begin
        n_checks++;
        if ({done, done_id, hits} !== {1'b1, IDW'(1), HW'(5)}) begin
          n_fail++; $display("FAIL single_done done=%b id=%0d hits=%0d required 1 1 5", done, done_id, hits);
        end
      end
    end
    n_checks++;
    if (xs !== 8'hB6 || gc != 10) begin
      n_fail++; $display("FAIL single_serial det_x=%h gnt_cycles=%0d required b6 and 10", xs, gc);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    logic [W-1:0] w1;
    drain_idle();
    data = rand_data(); w1 = data[W +: W]; req = 4'b0010;
    for (int r = 1; r <= W + 10; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL rstmid_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      if (done === 1'b1) nd++;
      if (r == 5) rst = 1'b1;
      if (r == 6) begin
        rst = 1'b0;
        n_checks++;
        if ({gnt, done, hits, done_id} !== '0) begin
          n_fail++; $display("FAIL rstmid_after gnt=%b done=%b hits=%0d id=%0d required all zero", gnt, done, hits, done_id);
        end
      end
      if (r == 7) req = '0;
      if (r == W + 9) begin
        n_checks++;
        if ({done, done_id, hits} !== {1'b1, IDW'(1), HW'($countones(w1))}) begin
          n_fail++; $display("FAIL rstmid_done done=%b id=%0d hits=%0d required 1 1 %0d", done, done_id, hits, $countones(w1));
        end
      end
    end
    n_checks++;
    if (nd != 1) begin
      n_fail++; $display("FAIL rstmid_dones count=%0d required 1", nd);
    end
  endtask

  task automatic test_fairness();
    int ids[3];
    int exp_ids[3] = '{2, 3, 0};
    int ns = 0;
    logic [N-1:0] pg;
    drain_idle();
    pg = gnt;
    data = rand_data(); req = 4'b0100;
    for (int r = 1; r <= 3 * TL; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL fair_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      if (r == 1) req = 4'b1001;
      if (r == 2 * TL + 1) req = '0;
      if (gnt !== '0 && pg === '0) begin
        if (ns < 3) ids[ns] = oh_idx(gnt);
        ns++;
      end
      pg = gnt;
    end
    n_checks++;
    if (ns != 3 || ids[0] != exp_ids[0] || ids[1] != exp_ids[1] || ids[2] != exp_ids[2]) begin
      n_fail++; $display("FAIL fair_order grants=%0d ids=%0d,%0d,%0d required 3 grants 2,3,0", ns, ids[0], ids[1], ids[2]);
    end
  endtask

  task automatic test_window();
    logic [W-1:0] words[2] = '{8'hFF, 8'h00};
    int exp_h[2] = '{8, 0};
    det_mode = 2;
    for (int k = 0; k < 2; k++) begin
      drain_idle();
      data = rand_data(); data[0 +: W] = words[k]; req = 4'b0001;
      for (int r = 1; r <= TL; r++) begin
        step();
        n_checks++;
        if (obs_vec() !== exp_vec) begin
          n_fail++; $display("FAIL window_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
        end
        if (r == 1) req = '0;
        if (r == W + 3) begin
          n_checks++;
          if (done !== 1'b1 || hits !== HW'(exp_h[k])) begin
            n_fail++; $display("FAIL window_hits word=%h done=%b hits=%0d required 1 %0d", words[k], done, hits, exp_h[k]);
          end
        end
      end
    end
    det_mode = 0;
  endtask

  task automatic test_random();
    det_mode = 1;
    for (int r = 0; r < 500; r++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++; $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec);
      end
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      data = rand_data();
      rst  = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    det_mode = 0;
    drain_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_reset_mid();
    test_fairness();
    test_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_stream_arbiter.md
# fsm_stream_arbiter

Round-robin scheduler that shares one serial sequence-detector FSM (single-bit input `x`, single-bit output `y`) among several requesters. Each requester presents a parallel word. The arbiter grants one requester, clears the detector, and shifts the word into it MSB-first. It counts the cycles in which the detector output is high and returns that hit count to the granted requester with a one-cycle done pulse. It sits between the requester blocks and the shared detector instance.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `WORD_W`, default 8: bits per word shifted into the detector.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `data`  in  N_REQ*WORD_W  requester i word at `data[i*WORD_W +: WORD_W]`.
- `gnt`  out  N_REQ  one-hot grant, held for the whole transfer.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `done_id`  out  clog2(N_REQ)  index of the requester that just completed; held until the next `done`.
- `hits`  out  clog2(WORD_W+1)  detector-high count for the completed word; held until the next `done`.
- `det_rst_n`  out  1  active-low clear to the shared detector.
- `det_x`  out  1  serial bit to the detector.
- `det_y`  in  1  detector output.

## Operation
- States and transitions:
  - IDLE: waits for any request; on one, goes to CLEAR.
  - CLEAR: 1 cycle; goes to SHIFT.
  - SHIFT: WORD_W cycles; goes to DRAIN.
  - DRAIN: 1 cycle; goes to DONE.
  - DONE: 1 cycle; goes to IDLE.
- Reset values: state IDLE, `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `hits`=0, `det_x`=0, `det_rst_n`=0, priority pointer `ptr`=0, bit counter 0.
- IDLE, with any `req` high:
  - Select the first requester with `req` high, searching from `ptr` upward modulo N_REQ.
  - Latch its `data` slice into the shift register and its index into an internal grant id.
  - Register `gnt`.
  - `req` sampled only in IDLE.
- CLEAR:
  - `det_rst_n`=0, `det_x`=0.
  - Clear the hit accumulator.
- SHIFT:
  - `det_x` = shift-register MSB.
  - Shift left each cycle; bit counter advances 0..WORD_W-1.
  - Leave SHIFT after counter reaches WORD_W-1.
- DRAIN: `det_x`=0.
- Counting window:
  - `det_y` is sampled in the WORD_W cycles starting at the second SHIFT cycle and ending with DRAIN.
  - The detector has one-cycle latency: `det_y` in cycle k+1 answers the bit presented in cycle k.
  - Accumulator += 1 per high sample. `det_y` outside the window is ignored.
  - Maximum count is WORD_W; the accumulator cannot overflow.
- DONE:
  - `done`=1; `gnt`=0.
  - `done_id` ← grant id; `hits` ← accumulator.
  - `ptr` ← (grant id + 1) mod N_REQ.
- `det_rst_n`=1 in every state except CLEAR and except while `rst` is high.
- Dropping `req` mid-transfer is ignored: the transfer completes and `done` is still issued.
- Changing `data` after the IDLE sample has no effect.
- `req` still high in the IDLE after DONE is treated as a new request and arbitrated normally against the updated `ptr`.
- Reset mid-operation: the next cycle is IDLE with all reset values. No `done` is issued, `hits` and `done_id` clear, `ptr` returns to 0.

## Timing
- Let t be the IDLE cycle in which `req` is sampled.
- `gnt`/`busy` high t+1..t+10 for WORD_W=8 (generally t+1..t+WORD_W+2); `busy` also high at t+11.
- CLEAR at t+1 (`det_rst_n` low).
- SHIFT t+2..t+WORD_W+1.
- DRAIN t+WORD_W+2.
- DONE (`done` pulse) t+WORD_W+3; `hits`/`done_id` valid from t+WORD_W+3.
- Back-to-back service: IDLE at t+WORD_W+4; next grant period begins t+WORD_W+5.
- Grant-to-grant spacing is WORD_W+4 cycles (12 for defaults).
- No combinational path from `req`, `data` or `det_y` to any output.

## Test plan
- Reset: `rst` high 2 cycles with all `req` high -> `gnt`=0, `busy`=0, `done`=0, `hits`=0, `det_rst_n`=0, `det_x`=0; first grant occurs only after `rst` falls.
- Single transfer, echo detector (`det_y` = `det_x` delayed one cycle): `req[1]`=1, word 8'hB6 -> `gnt`=4'b0010 for 10 cycles; `det_x` sequence 1,0,1,1,0,1,1,0; `done` at t+11 with `done_id`=1, `hits`=5.
- All four `req` high from reset release, held -> grants 0,1,2,3,0 in order, grant periods starting 12 cycles apart, one `done` per grant.
- Fairness: after serving requester 2, `req[0]` and `req[3]` high -> requester 3 granted first, then 0.
- Reset during SHIFT cycle 4 of requester 1's transfer -> next cycle `gnt`=0, no `done`, `ptr`=0; `req[1]` still high -> fresh full transfer, correct `hits`.
- Window boundary: `det_y` forced 1 during IDLE and CLEAR, then echo model with word 8'hFF -> `hits`=8 (maximum; the forced-high samples are not counted); word 8'h00 -> `hits`=0.
